// File: rtl/dual_issue_scheduler_if.sv
// Instruction-pair handshake between the fetch/decode stage and the dual-issue scheduler.
// The master drives the pair and branch flush; the slave returns issue routing and acknowledge.
interface dual_issue_scheduler_if #(
  parameter int ADDR_W = 7
);
  logic              in_valid;
  logic              s0_en;
  logic              s1_en;
  logic              s0_pipe;
  logic              s1_pipe;
  logic [ADDR_W-1:0] s0_ra;
  logic [ADDR_W-1:0] s0_rb;
  logic [ADDR_W-1:0] s0_rc;
  logic [ADDR_W-1:0] s1_ra;
  logic [ADDR_W-1:0] s1_rb;
  logic [ADDR_W-1:0] s1_rc;
  logic [2:0]        s0_use;
  logic [2:0]        s1_use;
  logic [ADDR_W-1:0] s0_rt;
  logic [ADDR_W-1:0] s1_rt;
  logic              s0_we;
  logic              s1_we;
  logic [2:0]        s0_lat;
  logic [2:0]        s1_lat;
  logic              branch_taken;
  logic              ep_issue;
  logic              ep_slot;
  logic              op_issue;
  logic              op_slot;
  logic              pair_ack;
  logic              stall;

  modport master (
    output in_valid, s0_en, s1_en, s0_pipe, s1_pipe,
           s0_ra, s0_rb, s0_rc, s1_ra, s1_rb, s1_rc,
           s0_use, s1_use, s0_rt, s1_rt, s0_we, s1_we,
           s0_lat, s1_lat, branch_taken,
    input  ep_issue, ep_slot, op_issue, op_slot, pair_ack, stall
  );

  modport slave (
    input  in_valid, s0_en, s1_en, s0_pipe, s1_pipe,
           s0_ra, s0_rb, s0_rc, s1_ra, s1_rb, s1_rc,
           s0_use, s1_use, s0_rt, s1_rt, s0_we, s1_we,
           s0_lat, s1_lat, branch_taken,
    output ep_issue, ep_slot, op_issue, op_slot, pair_ack, stall
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: routes an instruction pair to the even/odd pipes,
// blocking on RAW/WAW hazards tracked by a per-pipe latency scoreboard.
module dual_issue_scheduler #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 7
) (
  input  logic clk,
  input  logic rst,
  dual_issue_scheduler_if.slave bus
);

  typedef enum logic {ST_PAIR, ST_SECOND} state_t;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] rt;
    logic [2:0]        rem;
  } entry_t;

  state_t r_state;
  state_t w_state_next;
  entry_t r_sb [2][DEPTH];
  entry_t w_new [2];

  logic       w_h0, w_h1, w_dep01;
  logic [2:0] w_lat0, w_lat1;
  logic       w_s0_iss, w_s0_done, w_s1_iss, w_s1_done, w_go;
  logic       w_ep_issue, w_ep_slot, w_op_issue, w_op_slot, w_ack;

  function automatic logic src_match(input logic [2:0] src_used,
                                     input logic [ADDR_W-1:0] ra,
                                     input logic [ADDR_W-1:0] rb,
                                     input logic [ADDR_W-1:0] rc,
                                     input logic [ADDR_W-1:0] rt);
    return (src_used[2] && ra == rt) || (src_used[1] && rb == rt) ||
           (src_used[0] && rc == rt);
  endfunction

  // Hazard detection against every tracked entry of both pipes.
  always_comb begin
    w_h0    = 1'b0;
    w_h1    = 1'b0;
    w_lat0  = (bus.s0_lat == 3'd0) ? 3'd1 : bus.s0_lat;
    w_lat1  = (bus.s1_lat == 3'd0) ? 3'd1 : bus.s1_lat;
    w_dep01 = bus.s0_en && bus.s0_we &&
              src_match(bus.s1_use, bus.s1_ra, bus.s1_rb, bus.s1_rc, bus.s0_rt);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_sb[p][k].v) begin
          if (r_sb[p][k].rem >= 3'd2 &&
              src_match(bus.s0_use, bus.s0_ra, bus.s0_rb, bus.s0_rc, r_sb[p][k].rt))
            w_h0 = 1'b1;
          if (bus.s0_we && r_sb[p][k].rt == bus.s0_rt && r_sb[p][k].rem > w_lat0)
            w_h0 = 1'b1;
          if (r_sb[p][k].rem >= 3'd2 &&
              src_match(bus.s1_use, bus.s1_ra, bus.s1_rb, bus.s1_rc, r_sb[p][k].rt))
            w_h1 = 1'b1;
          if (bus.s1_we && r_sb[p][k].rt == bus.s1_rt && r_sb[p][k].rem > w_lat1)
            w_h1 = 1'b1;
        end
      end
    end
  end

  // Issue decision, pipe routing, scoreboard insertion and next state.
  always_comb begin
    w_s0_iss     = 1'b0;
    w_s0_done    = 1'b0;
    w_s1_iss     = 1'b0;
    w_s1_done    = 1'b0;
    w_ep_issue   = 1'b0;
    w_ep_slot    = 1'b0;
    w_op_issue   = 1'b0;
    w_op_slot    = 1'b0;
    w_ack        = 1'b0;
    w_new[0]     = '0;
    w_new[1]     = '0;
    w_state_next = r_state;
    w_go         = bus.in_valid && !bus.branch_taken;

    case (r_state)
      ST_PAIR: begin
        w_s0_iss  = bus.s0_en && !w_h0;
        w_s0_done = !bus.s0_en || !w_h0;
        w_s1_iss  = bus.s1_en && w_s0_done && !w_h1 && !w_dep01 &&
                    !(bus.s0_en && bus.s0_pipe == bus.s1_pipe);
        w_s1_done = w_s0_done && (!bus.s1_en || w_s1_iss);
      end
      ST_SECOND: begin
        w_s0_done = 1'b1;
        w_s1_iss  = bus.s1_en && !w_h1;
        w_s1_done = !bus.s1_en || !w_h1;
      end
      default: ;
    endcase

    if (w_go) begin
      if (w_s0_iss) begin
        if (bus.s0_pipe) w_op_issue = 1'b1;
        else             w_ep_issue = 1'b1;
        if (bus.s0_we) w_new[bus.s0_pipe] = '{v: 1'b1, rt: bus.s0_rt, rem: w_lat0};
      end
      if (w_s1_iss) begin
        if (bus.s1_pipe) begin
          w_op_issue = 1'b1;
          w_op_slot  = 1'b1;
        end else begin
          w_ep_issue = 1'b1;
          w_ep_slot  = 1'b1;
        end
        if (bus.s1_we) w_new[bus.s1_pipe] = '{v: 1'b1, rt: bus.s1_rt, rem: w_lat1};
      end
      w_ack = w_s1_done;
      if (w_ack)                                w_state_next = ST_PAIR;
      else if (r_state == ST_PAIR && w_s0_done) w_state_next = ST_SECOND;
    end

    if (bus.branch_taken) w_state_next = ST_PAIR;
  end

  assign bus.ep_issue = !rst && w_ep_issue;
  assign bus.ep_slot  = !rst && w_ep_slot;
  assign bus.op_issue = !rst && w_op_issue;
  assign bus.op_slot  = !rst && w_op_slot;
  assign bus.pair_ack = !rst && w_ack;
  assign bus.stall    = !rst && bus.in_valid && !w_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_PAIR;
    else     r_state <= w_state_next;
  end

  // Entries age by one stage per edge; remaining latency saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < DEPTH; k++)
          r_sb[p][k] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_sb[p][0] <= w_new[p];
        for (int k = 1; k < DEPTH; k++) begin
          r_sb[p][k].v   <= r_sb[p][k-1].v;
          r_sb[p][k].rt  <= r_sb[p][k-1].rt;
          r_sb[p][k].rem <= (r_sb[p][k-1].rem == 3'd0) ? 3'd0 : r_sb[p][k-1].rem - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed scoreboard bench for dual_issue_scheduler: the driver queues hand-computed
// per-cycle expectations and a negedge monitor pops and compares them.
module tb_dual_issue_scheduler;

  typedef struct {
    string name;
    logic  ep;
    logic  eps;
    logic  op;
    logic  ops;
    logic  ack;
    logic  st;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   vectors;
  int   miscompares;

  dual_issue_scheduler_if #(.ADDR_W(7)) bus ();

  dual_issue_scheduler #(.ADDR_W(7), .DEPTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setSlot(input int s, input logic en, input logic pipe,
                         input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                         input logic [2:0] srcUse, input logic [6:0] rt,
                         input logic we, input logic [2:0] lat);
    if (s == 0) begin
      bus.s0_en = en; bus.s0_pipe = pipe; bus.s0_ra = ra; bus.s0_rb = rb; bus.s0_rc = rc;
      bus.s0_use = srcUse; bus.s0_rt = rt; bus.s0_we = we; bus.s0_lat = lat;
    end else begin
      bus.s1_en = en; bus.s1_pipe = pipe; bus.s1_ra = ra; bus.s1_rb = rb; bus.s1_rc = rc;
      bus.s1_use = srcUse; bus.s1_rt = rt; bus.s1_we = we; bus.s1_lat = lat;
    end
  endtask

  task automatic applyStimulus(input string name, input logic valid, input logic br,
                               input logic ep, input logic eps, input logic op,
                               input logic ops, input logic ack, input logic st);
    exp_t e;
    bus.in_valid     = valid;
    bus.branch_taken = br;
    e.name = name; e.ep = ep; e.eps = eps; e.op = op; e.ops = ops; e.ack = ack; e.st = st;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic bad;
    vectors++;
    bad = (bus.ep_issue !== e.ep) || (bus.op_issue !== e.op) ||
          (bus.pair_ack !== e.ack) || (bus.stall !== e.st) ||
          (e.ep && bus.ep_slot !== e.eps) || (e.op && bus.op_slot !== e.ops);
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s: got ep=%b/%b op=%b/%b ack=%b stall=%b, expected ep=%b/%b op=%b/%b ack=%b stall=%b",
               e.name, bus.ep_issue, bus.ep_slot, bus.op_issue, bus.op_slot, bus.pair_ack, bus.stall,
               e.ep, e.eps, e.op, e.ops, e.ack, e.st);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.branch_taken = 1'b0;
    setSlot(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    setSlot(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    @(posedge clk);
    #1;

    // Outputs held at zero while reset is active, even with a valid pair presented
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd3, 1, 3'd1);
    setSlot(1, 1, 1, 7'd4, 0, 0, 3'b100, 7'd0, 0, 3'd1);
    applyStimulus("reset_hold0", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset_hold1", 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus("dual_issue", 1, 0, 1, 0, 1, 1, 1, 0);

    // Both slots on the even pipe
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd10, 1, 3'd1);
    setSlot(1, 1, 0, 0, 0, 0, 3'b000, 7'd11, 1, 3'd1);
    applyStimulus("same_pipe_c0", 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus("same_pipe_c1", 1, 0, 1, 1, 0, 0, 1, 0);

    // Intra-pair dependency s0 rt=5 -> s1 ra=5
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd5, 1, 3'd1);
    setSlot(1, 1, 1, 7'd5, 0, 0, 3'b100, 7'd0, 0, 3'd1);
    applyStimulus("intra_dep_c0", 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus("intra_dep_c1", 1, 0, 0, 0, 1, 1, 1, 0);

    // RAW on rt=9 with L=6: consumer stalls five cycles
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd9, 1, 3'd6);
    setSlot(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    applyStimulus("raw6_prod", 1, 0, 1, 0, 0, 0, 1, 0);
    setSlot(0, 1, 1, 0, 7'd9, 0, 3'b010, 7'd0, 0, 3'd1);
    for (int i = 1; i <= 5; i++) applyStimulus($sformatf("raw6_stall%0d", i), 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("raw6_issue", 1, 0, 0, 0, 1, 0, 1, 0);

    // RAW with L=1: consumer issues the next cycle
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd9, 1, 3'd1);
    applyStimulus("raw1_prod", 1, 0, 1, 0, 0, 0, 1, 0);
    setSlot(0, 1, 1, 0, 7'd9, 0, 3'b010, 7'd0, 0, 3'd1);
    applyStimulus("raw1_issue", 1, 0, 0, 0, 1, 0, 1, 0);

    // WAW on rt=20: older L=4, younger L=2 waits until rem drops to 2
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd20, 1, 3'd4);
    applyStimulus("waw_prod", 1, 0, 1, 0, 0, 0, 1, 0);
    setSlot(0, 1, 1, 0, 0, 0, 3'b000, 7'd20, 1, 3'd2);
    applyStimulus("waw_stall1", 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("waw_stall2", 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("waw_issue", 1, 0, 0, 0, 1, 0, 1, 0);

    // Branch flush while slot 1 is hazard-blocked in SECOND
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd30, 1, 3'd7);
    applyStimulus("flush_prod", 1, 0, 1, 0, 0, 0, 1, 0);
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd31, 0, 3'd1);
    setSlot(1, 1, 1, 7'd30, 0, 0, 3'b100, 7'd0, 0, 3'd1);
    applyStimulus("flush_s0", 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus("flush_branch", 1, 1, 0, 0, 0, 0, 0, 1);
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd40, 1, 3'd1);
    setSlot(1, 1, 1, 0, 7'd41, 0, 3'b010, 7'd0, 0, 3'd1);
    applyStimulus("flush_newpair", 1, 0, 1, 0, 1, 1, 1, 0);

    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-operation reset drops tracking of an L=7 producer
    setSlot(0, 1, 0, 0, 0, 0, 3'b000, 7'd50, 1, 3'd7);
    setSlot(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    applyStimulus("rst_prod", 1, 0, 1, 0, 0, 0, 1, 0);
    setSlot(0, 1, 1, 7'd50, 0, 0, 3'b100, 7'd0, 0, 3'd1);
    applyStimulus("rst_cons_stall", 1, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    applyStimulus("rst_active", 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus("rst_cons_issue", 1, 0, 0, 0, 1, 0, 1, 0);

    bus.in_valid = 1'b0;
    for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
